stepper_motor_ctrl: RTL and testbench
=====================================

Name: stepper_motor_ctrl

Overview:
- Parametrised closed-count stepper controller.
- Accepts move commands (absolute target position, step period, step mode) over a valid/ready handshake.
- Generates timed 4-phase coil patterns in full-step or half-step mode and tracks absolute position.
- Sits between the motion sequencer and the coil driver pins; all coil outputs are registered.

Parameters:
POS_W, 16, width of position/target counters (two's complement, wraps modulo 2^POS_W)
DIV_W, 20, width of step-period counter in system1000 cycles

Ports:
system1000  in  1  clock
system1000_rstn  in  1  reset, asynchronous, active-low
enable  in  1  coil energise; 0 forces coils to 4'b0000 (position/state unaffected)
cmd_valid  in  1  move command valid
cmd_ready  out  1  high when block can accept a command
cmd_target  in  POS_W  absolute target position
cmd_period  in  DIV_W  cycles per step; 0 treated as 1
cmd_half  in  1  1 = half-step mode, 0 = full-step mode
abort  in  1  stop current move
coils  out  4  registered coil pattern {A,B,C,D}
position  out  POS_W  current absolute position
busy  out  1  move in progress
done  out  1  one-cycle pulse at end of move (normal or aborted)

Behaviour:
- Reset: coils=0000, position=0, phase index=0, state=IDLE, cmd_ready=1, busy=0, done=0, tick counter=0.
- Phase table, indices 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Coils register: next value = enable ? table[idx] : 0000. Registered one cycle after idx/enable change.
- Stepping:
  - Half-step mode: idx ±1 mod 8.
  - Full-step mode: idx ±2 mod 8. Parity is preserved: even idx gives wave drive, odd idx gives two-phase.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - RUN: busy=1, cmd_ready=0.
  - DONE: one cycle, done=1, cmd_ready=0; then returns to IDLE.
- Accept: cmd_valid && cmd_ready in IDLE latches target, period (0→1) and mode.
  - diff = target − position (POS_W, signed).
  - diff==0: go directly to DONE with no step.
  - Otherwise: go to RUN with dir = sign(diff) (negative → decrement) and tick = period−1. Wrap takes the shortest signed path; diff = −2^(POS_W−1) steps negative.
- RUN: tick decrements each cycle. When tick==0:
  - take one step (idx update, position ±1 mod 2^POS_W) and reload tick = period−1;
  - if the new position == target, go to DONE.
  - The first step therefore occurs `period` cycles after accept; coils reflect it one cycle later.
- position is updated on the step cycle and is visible the next cycle (registered).
- abort in RUN: no further steps; go to DONE next cycle. position and idx hold the last stepped values. abort in IDLE/DONE is ignored.
- abort on the same cycle as a tick==0 step: the step is taken, then DONE.
- cmd_valid while not ready is ignored; the command must be held by the source until accepted.
- enable low during RUN: timing and position continue, coils=0000 (step loss is the caller's responsibility).
- Reset mid-move: immediate return to reset values. Coils de-energise asynchronously.

Test Plan:
1. Reset, enable=1, cmd target=3, period=4, half=1 → steps at cycles 4, 8, 12 after accept; coils 1100, 0100, 0110; position 1, 2, 3; done pulse on the cycle after the step-3 position update; busy low after done.
2. From position 3, idx 3: target=0, period=1, half=0 → idx 1, 7, 5; coils 1100, 1001, 0011 on consecutive cycles; position 2, 1, 0; done once.
3. POS_W=16, position=0: target=16'hFFFE, period=2 → 2 negative steps; position FFFF, FFFE; no forward wrap traversal.
4. target equal to current position → no coil change; done at the cycle after accept; cmd_ready low for exactly 1 cycle.
5. target=100, period=10, abort asserted at cycle 35 after accept → exactly 3 steps, position=3, done pulse next cycle; a new command is accepted the following cycle.
6. enable=0 throughout a 2-step move → coils stay 0000, position advances to 2; raising enable afterwards → coils=table[idx] one cycle later. Asserting rstn low mid-move → coils=0000 and position=0 immediately.

Source files
------------

// File: rtl/stepper_motor_ctrl.sv
// Closed-count stepper controller: accepts absolute move commands and steps a
// 4-phase coil pattern (full or half step) until the tracked position reaches the target.
module stepper_motor_ctrl #(
  parameter int POS_W = 16,
  parameter int DIV_W = 20
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             cmd_half,
  input  logic             abort,
  output logic [3:0]       coils,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic [2:0]         idx_q, idx_d;
  logic               half_q, half_d;
  logic               dir_q, dir_d;
  logic [3:0]         coils_q, coils_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [POS_W-1:0]   diff;
  logic [DIV_W-1:0]   eff_period;
  logic [POS_W-1:0]   pos_stepped;
  logic [2:0]         idx_delta;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_pattern = 4'b1000;
      3'd1:    phase_pattern = 4'b1100;
      3'd2:    phase_pattern = 4'b0100;
      3'd3:    phase_pattern = 4'b0110;
      3'd4:    phase_pattern = 4'b0010;
      3'd5:    phase_pattern = 4'b0011;
      3'd6:    phase_pattern = 4'b0001;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    period_d = period_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    half_d   = half_q;
    dir_d    = dir_q;

    // Modular subtraction gives the shortest signed path, including across the wrap.
    diff        = cmd_target - pos_q;
    eff_period  = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
    pos_stepped = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
    // Backward moves add the 3-bit two's complement of the stride (7 = -1, 6 = -2).
    idx_delta   = dir_q ? (half_q ? 3'd7 : 3'd6) : (half_q ? 3'd1 : 3'd2);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          period_d = eff_period;
          half_d   = cmd_half;
          dir_d    = diff[POS_W-1];
          tick_d   = eff_period - DIV_W'(1);
          state_d  = (diff == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick_q == '0) begin
          pos_d  = pos_stepped;
          idx_d  = idx_q + idx_delta;
          tick_d = period_q - DIV_W'(1);
          if ((pos_stepped == target_q) || abort) begin
            state_d = ST_DONE;
          end
        end else begin
          tick_d = tick_q - DIV_W'(1);
          if (abort) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    coils_d = enable ? phase_pattern(idx_q) : 4'b0000;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      target_q <= '0;
      period_q <= DIV_W'(1);
      tick_q   <= '0;
      idx_q    <= 3'd0;
      half_q   <= 1'b0;
      dir_q    <= 1'b0;
      coils_q  <= 4'b0000;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      half_q   <= half_d;
      dir_q    <= dir_d;
      coils_q  <= coils_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign coils     = coils_q;
  assign position  = pos_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_stepper_motor_ctrl.sv
// Bench for stepper_motor_ctrl: directed plan plus random moves, each checked cycle by
// cycle against an arithmetic model (steps taken = elapsed/period, capped at move length).
module tb_stepper_motor_ctrl;
  localparam int POS_W = 16;
  localparam int DIV_W = 20;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             enable = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_target = '0;
  logic [DIV_W-1:0] cmd_period = '0;
  logic             cmd_half = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       coils;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: position and phase index after the last completed move.
  logic [15:0] mpos = '0;
  int          midx = 0;
  logic [3:0]  tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                           4'b0010, 4'b0011, 4'b0001, 4'b1001};

  always #5 clk = ~clk;

  stepper_motor_ctrl #(.POS_W(POS_W), .DIV_W(DIV_W)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .enable          (enable),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_target      (cmd_target),
    .cmd_period      (cmd_period),
    .cmd_half        (cmd_half),
    .abort           (abort),
    .coils           (coils),
    .position        (position),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mod8(input int x);
    return ((x % 8) + 8) % 8;
  endfunction

  // Issue one command at the next edge (edge 0) and check every cycle through the done pulse
  // and the first idle cycle. abort_at > 0 raises abort so it is sampled at edge abort_at.
  task automatic run_move(input string name, input logic [15:0] target, input int period,
                          input bit half, input int abort_at, input bit en);
    logic [15:0] d;
    logic [15:0] epos;
    int n, dir, stp, p, e, s, sp;
    d   = target - mpos;
    dir = d[15] ? -1 : 1;
    n   = d[15] ? (65536 - int'(d)) : int'(d);
    stp = half ? 1 : 2;
    p   = (period == 0) ? 1 : period;
    e   = n * p;
    if (abort_at > 0 && n > 0 && abort_at < e) e = abort_at;

    enable     = en;
    cmd_target = target;
    cmd_period = DIV_W'(period);
    cmd_half   = half;
    cmd_valid  = 1'b1;
    for (int c = 0; c <= e + 1; c++) begin
      abort = (c > 0 && c == abort_at);
      @(posedge clk); #1;
      abort = 1'b0;
      if (c == 0) cmd_valid = 1'b0;
      s    = ((c < e) ? c : e) / p;
      sp   = (c == 0) ? 0 : (((c - 1 < e) ? c - 1 : e) / p);
      epos = mpos + 16'(dir * s);
      check($sformatf("%s.pos c%0d", name, c), 32'(position), 32'(epos));
      check($sformatf("%s.busy c%0d", name, c), 32'(busy), 32'(c < e));
      check($sformatf("%s.done c%0d", name, c), 32'(done), 32'(c == e));
      check($sformatf("%s.ready c%0d", name, c), 32'(cmd_ready), 32'(c > e));
      check($sformatf("%s.coils c%0d", name, c), 32'(coils),
            en ? 32'(tbl[mod8(midx + dir * stp * sp)]) : 32'd0);
    end
    s    = e / p;
    mpos = mpos + 16'(dir * s);
    midx = mod8(midx + dir * stp * s);
  endtask

  // Assert reset away from any clock edge; outputs must clear without waiting for a clock.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check({name, ".coils"}, 32'(coils), 32'd0);
    check({name, ".pos"}, 32'(position), 32'd0);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".done"}, 32'(done), 32'd0);
    check({name, ".ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    mpos = '0;
    midx = 0;
  endtask

  initial begin
    logic [15:0] tgt;
    int delta, per, ab;
    bit hf, en;

    do_reset("reset");

    // 1: half-step, three steps every 4 cycles.
    run_move("t1", 16'd3, 4, 1'b1, 0, 1'b1);
    // 2: full-step backwards from odd index, period 1.
    run_move("t2", 16'd0, 1, 1'b0, 0, 1'b1);
    // 3: short path across the wrap, negative direction.
    run_move("t3", 16'hFFFE, 2, 1'b1, 0, 1'b1);
    // 4: target equals position.
    run_move("t4", 16'hFFFE, 3, 1'b0, 0, 1'b1);
    // 5: long move aborted at cycle 35, then an immediate new command.
    do_reset("rst5");
    run_move("t5", 16'd100, 10, 1'b1, 35, 1'b1);
    run_move("t5b", 16'd1, 0, 1'b1, 0, 1'b1);
    // 6: coils held off during a move, then re-energised.
    do_reset("rst6");
    run_move("t6", 16'd2, 3, 1'b0, 0, 1'b0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("t6.reenable", 32'(coils), 32'(tbl[midx]));

    for (int i = 0; i < 30; i++) begin
      delta = int'($urandom_range(0, 12)) - 6;
      per   = int'($urandom_range(0, 5));
      hf    = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 4) != 0);
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      tgt   = mpos + 16'(delta);
      run_move($sformatf("rnd%0d", i), tgt, per, hf, ab, en);
    end

    // Reset in the middle of a move.
    enable     = 1'b1;
    cmd_target = mpos + 16'd50;
    cmd_period = DIV_W'(2);
    cmd_half   = 1'b1;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid.pos_before", 32'(position), 32'(mpos + 16'd3));
    check("mid.busy_before", 32'(busy), 32'd1);
    do_reset("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
